// File: rtl/pfs_fetch_queue_pkg.sv
// Shared definitions for the pre-IF fetch queue: bus widths, fixed vectors and the buffer entry layout.
package pfs_fetch_queue_pkg;

    localparam int          PFS_TO_FS_BUS_WD = 64;
    localparam logic [31:0] EX_ENTRY         = 32'hbfc00380;
    localparam logic [31:0] PFS_RESET_PC     = 32'hbfc00000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } pfs_entry_t;

endpackage

// File: rtl/pfs_fetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; depth need not be a power of two.
module pfs_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Flush wins over push/pop so a same-cycle write is discarded with the rest.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/pfs_fetch_queue.sv
// Pre-IF fetch queue: pipelined inst_sram requests, in-order instruction buffer, redirect flush.
// Optional stale-return counter enabled with `define PFS_PERF_CNT_EN.
module pfs_fetch_queue
    import pfs_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = PFS_RESET_PC,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [31:0]                 redirect_pc,
    input  logic                        fs_allowin,
    output logic                        pfs_to_fs_valid,
    output logic [PFS_TO_FS_BUS_WD-1:0] pfs_to_fs_bus,
    output logic                        inst_sram_req,
    output logic [31:0]                 inst_sram_addr,
    input  logic                        inst_sram_addr_ok,
    input  logic [31:0]                 inst_sram_rdata,
    input  logic                        inst_sram_data_ok,
    output logic                        inst_sram_data_waiting,
    output logic [31:0]                 perf_discard_cnt
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   req_pc_q, req_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] discard_q, discard_d;
    logic [CW-1:0] buf_count;
    logic [OW-1:0] pc_count;
    logic [31:0]   pc_head;
    pfs_entry_t    ret_entry;
    logic          sram_accept, sram_return, drop_stale, buf_push, buf_pop;

    // A slot is reserved for every live request, so a return always has room.
    assign inst_sram_req = !reset && !redirect_valid
                         && (int'(outstanding_q) < MAX_OUTSTANDING)
                         && (int'(outstanding_q) + int'(buf_count) < BUF_DEPTH);
    assign inst_sram_addr = req_pc_q;

    assign sram_accept = inst_sram_req && inst_sram_addr_ok;
    assign sram_return = inst_sram_data_ok && (outstanding_q != '0);
    assign drop_stale  = sram_return && (discard_q != '0);
    assign buf_push    = sram_return && (discard_q == '0) && !redirect_valid;
    assign buf_pop     = pfs_to_fs_valid && fs_allowin && !redirect_valid;

    assign ret_entry = '{inst: inst_sram_rdata, pc: pc_head};

    always_comb begin
        req_pc_d      = req_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + OW'(sram_accept) - OW'(sram_return);
        if (sram_accept) req_pc_d = req_pc_q + 32'd4;
        if (redirect_valid) begin
            // Everything still in flight becomes stale, including entries already marked.
            req_pc_d  = redirect_pc;
            discard_d = outstanding_q - OW'(sram_return);
        end else if (drop_stale) begin
            discard_d = discard_q - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    pfs_sync_fifo #(.DATA_W(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .push      (sram_accept),
        .push_data (req_pc_q),
        .pop       (sram_return),
        .pop_data  (pc_head),
        .count     (pc_count)
    );

    pfs_sync_fifo #(.DATA_W(PFS_TO_FS_BUS_WD), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data (ret_entry),
        .pop       (buf_pop),
        .pop_data  (pfs_to_fs_bus),
        .count     (buf_count)
    );

    assign pfs_to_fs_valid        = (buf_count != '0);
    assign inst_sram_data_waiting = (outstanding_q != '0);

`ifdef PFS_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;
    logic        stale_ret;

    assign stale_ret = sram_return && ((discard_q != '0) || redirect_valid);

    always_comb begin
        perf_d = perf_q;
        if (stale_ret && (perf_q != 32'hffffffff)) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_discard_cnt = perf_q;
`else
    assign perf_discard_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inst_sram_data_ok && (outstanding_q == '0)));
            assert (pc_count == outstanding_q);
        end
    end

endmodule

// File: tb/tb_pfs_fetch_queue.sv
// Directed bench for pfs_fetch_queue: streaming, backpressure, outstanding cap, redirects, reset.
module tb_pfs_fetch_queue;

    localparam logic [31:0] B = 32'hbfc00000;
`ifdef PFS_PERF_CNT_EN
    localparam logic [31:0] PERF2 = 32'd2;
`else
    localparam logic [31:0] PERF2 = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fs_allowin = 1'b0;
    logic        pfs_to_fs_valid;
    logic [63:0] pfs_to_fs_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        inst_sram_data_ok = 1'b0;
    logic        inst_sram_data_waiting;
    logic [31:0] perf_discard_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pfs_fetch_queue dut (
        .clk                    (clk),
        .reset                  (reset),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .fs_allowin             (fs_allowin),
        .pfs_to_fs_valid        (pfs_to_fs_valid),
        .pfs_to_fs_bus          (pfs_to_fs_bus),
        .inst_sram_req          (inst_sram_req),
        .inst_sram_addr         (inst_sram_addr),
        .inst_sram_addr_ok      (inst_sram_addr_ok),
        .inst_sram_rdata        (inst_sram_rdata),
        .inst_sram_data_ok      (inst_sram_data_ok),
        .inst_sram_data_waiting (inst_sram_data_waiting),
        .perf_discard_cnt       (perf_discard_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return ~pc ^ 32'h0f0f0000;
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {inst_of(pc), pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic aok, input logic dok, input logic [31:0] rpc, input logic allow,
                         input logic redir = 1'b0, input logic [31:0] tgt = 32'h0);
        inst_sram_addr_ok = aok;
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? inst_of(rpc) : 32'h0;
        fs_allowin        = allow;
        redirect_valid    = redir;
        redirect_pc       = tgt;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst_req_low", inst_sram_req, 1'b0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and streaming
        do_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", pfs_to_fs_valid, 1'b0);
        chk("rst_waiting", inst_sram_data_waiting, 1'b0);
        chk("rst_perf", perf_discard_cnt, 32'h0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, i > 0, 32'(B + 32'(4 * (i - 1))), 1'b1);
            chk("stream_req", inst_sram_req, 1'b1);
            chk("stream_addr", inst_sram_addr, 32'(B + 32'(4 * i)));
            chk("stream_valid", pfs_to_fs_valid, i >= 2);
            if (i >= 2) chk("stream_bus", pfs_to_fs_bus, ent(32'(B + 32'(4 * (i - 2)))));
            cyc();
        end
        // Mid-stream reset
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("midrst_req", inst_sram_req, 1'b0);
        cyc();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("midrst_valid", pfs_to_fs_valid, 1'b0);
        chk("midrst_waiting", inst_sram_data_waiting, 1'b0);
        chk("midrst_perf", perf_discard_cnt, 32'h0);
        chk("midrst_addr", inst_sram_addr, B);
        chk("midrst_req_after", inst_sram_req, 1'b1);

        // Backpressure
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);      chk("bp_addr0", inst_sram_addr, B);       cyc();
        drive(1'b1, 1'b1, B, 1'b0);          chk("bp_addr1", inst_sram_addr, B + 4);   cyc();
        drive(1'b1, 1'b1, B + 4, 1'b0);      chk("bp_addr2", inst_sram_addr, B + 8);   cyc();
        drive(1'b1, 1'b1, B + 8, 1'b0);      chk("bp_addr3", inst_sram_addr, B + 12);
        chk("bp_req3", inst_sram_req, 1'b1);                                             cyc();
        drive(1'b1, 1'b1, B + 12, 1'b0);     chk("bp_req_stop", inst_sram_req, 1'b0);  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_req_full", inst_sram_req, 1'b0);
        chk("bp_head0", pfs_to_fs_bus, ent(B));                                          cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_head1", pfs_to_fs_bus, ent(B + 4));
        chk("bp_resume_req", inst_sram_req, 1'b1);
        chk("bp_resume_addr", inst_sram_addr, B + 16);                                   cyc();
        drive(1'b0, 1'b1, B + 16, 1'b1);     chk("bp_head2", pfs_to_fs_bus, ent(B + 8)); cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);      chk("bp_head3", pfs_to_fs_bus, ent(B + 12)); cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);      chk("bp_head4", pfs_to_fs_bus, ent(B + 16)); cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);      chk("bp_empty", pfs_to_fs_valid, 1'b0);

        // Outstanding cap
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1);      chk("cap_addr0", inst_sram_addr, B);      cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);      chk("cap_addr1", inst_sram_addr, B + 4);  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk("cap_req_stop", inst_sram_req, 1'b0);
        chk("cap_waiting", inst_sram_data_waiting, 1'b1);                                cyc();
        drive(1'b1, 1'b1, B, 1'b1);
        chk("cap_req_still", inst_sram_req, 1'b0);
        chk("cap_no_bypass", pfs_to_fs_valid, 1'b0);                                     cyc();
        drive(1'b0, 1'b1, B + 4, 1'b1);
        chk("cap_head0", pfs_to_fs_bus, ent(B));
        chk("cap_resume_addr", inst_sram_addr, B + 8);                                   cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("cap_head1", pfs_to_fs_bus, ent(B + 4));
        chk("cap_waiting_clr", inst_sram_data_waiting, 1'b0);                            cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);      chk("cap_empty", pfs_to_fs_valid, 1'b0);

        // Redirect with two stale returns
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1);                                                  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);                                                  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hbfc00380);
        chk("rd_req_blocked", inst_sram_req, 1'b0);                                      cyc();
        drive(1'b1, 1'b1, B, 1'b1);
        chk("rd_req_cap", inst_sram_req, 1'b0);
        chk("rd_valid0", pfs_to_fs_valid, 1'b0);                                         cyc();
        drive(1'b1, 1'b1, B + 4, 1'b1);
        chk("rd_new_addr", inst_sram_addr, 32'hbfc00380);
        chk("rd_valid1", pfs_to_fs_valid, 1'b0);                                         cyc();
        drive(1'b0, 1'b1, 32'hbfc00380, 1'b1);
        chk("rd_valid2", pfs_to_fs_valid, 1'b0);
        chk("rd_next_addr", inst_sram_addr, 32'hbfc00384);
        chk("rd_perf", perf_discard_cnt, PERF2);                                         cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rd_valid3", pfs_to_fs_valid, 1'b1);
        chk("rd_first_bus", pfs_to_fs_bus, ent(32'hbfc00380));

        // Redirect coinciding with a return, buffer non-empty
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);                                                  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b0);                                                  cyc();
        drive(1'b1, 1'b1, B, 1'b0);                                                      cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b0);      chk("co_addr", inst_sram_addr, B + 8);    cyc();
        drive(1'b1, 1'b1, B + 4, 1'b1, 1'b1, 32'h00000100);
        chk("co_req_blocked", inst_sram_req, 1'b0);
        chk("co_head_held", pfs_to_fs_bus, ent(B));                                      cyc();
        drive(1'b1, 1'b1, B + 8, 1'b1);
        chk("co_flushed", pfs_to_fs_valid, 1'b0);
        chk("co_new_addr", inst_sram_addr, 32'h00000100);                                cyc();
        drive(1'b0, 1'b1, 32'h00000100, 1'b1);
        chk("co_perf", perf_discard_cnt, PERF2);                                         cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("co_valid", pfs_to_fs_valid, 1'b1);
        chk("co_bus", pfs_to_fs_bus, ent(32'h00000100));

        // Back-to-back redirects
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1);                                                  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1);                                                  cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00000100);
        chk("bb_req0", inst_sram_req, 1'b0);                                             cyc();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00000200);
        chk("bb_req1", inst_sram_req, 1'b0);                                             cyc();
        drive(1'b1, 1'b1, B, 1'b1);          chk("bb_req2", inst_sram_req, 1'b0);      cyc();
        drive(1'b1, 1'b1, B + 4, 1'b1);      chk("bb_addr", inst_sram_addr, 32'h00000200); cyc();
        drive(1'b0, 1'b1, 32'h00000200, 1'b1);
        chk("bb_no_early", pfs_to_fs_valid, 1'b0);                                       cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        chk("bb_bus", pfs_to_fs_bus, ent(32'h00000200));                                 cyc();
        drive(1'b0, 1'b0, 32'h0, 1'b1);      chk("bb_empty", pfs_to_fs_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
